csa_resolver: RTL and testbench
===============================

// Module: csa_resolver
// PURPOSE
//  Back end of the carry-save datapath. Takes a redundant (sum, carry) vector pair from a
//  6-bit 3:2 compressor stage and resolves it to one binary value: sum + (carry << 1).
//  Resolution is a chunked ripple, CHUNK bits per clock, so a narrow adder serves any WIDTH.
//  valid/ready on both sides; sits between the CSA array and any binary consumer.
// PARAMETERS
//  WIDTH  6  width of the sum and carry input vectors
//  CHUNK  2  bits resolved per clock; 1 <= CHUNK <= WIDTH+1
//  Derived: OPW = WIDTH+1 (operand width); NCH = ceil(OPW/CHUNK) (chunk count);
//           RW = WIDTH+2 (result width)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      sum_in/carry_in valid
//  in_ready   out  1      block can accept an operand pair
//  sum_in     in   WIDTH  sum vector, weight 2^i
//  carry_in   in   WIDTH  carry vector, weight 2^(i+1)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts the result
//  result     out  RW     {1'b0,sum_in} + {carry_in,1'b0}
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, result=0,
//    chunk counter=0, ripple carry=0.
//  - Operand A = {1'b0,sum_in}; operand B = {carry_in,1'b0}; both OPW bits.
//    Both are zero-extended to NCH*CHUNK bits.
//  - FSM states:
//    IDLE: in_ready=1. On in_valid&in_ready, latch A and B, set cnt=0 and c=0, go to RUN.
//    RUN: in_ready=0. Each clock adds chunk cnt of A and B plus c, writes the CHUNK-bit
//      sum into the result accumulator, updates c, increments cnt.
//      At cnt==NCH-1: result[RW-1] is the final carry, go to DONE.
//    DONE: out_valid=1, result stable. On out_ready go to IDLE, out_valid=0 next clock.
//  - Latency: out_valid rises exactly NCH clocks after the accepting edge
//    (WIDTH=6, CHUNK=2 -> 4).
//  - Result never overflows RW bits: max is 3*(2^WIDTH-1).
//  - Inputs are sampled only at the accepting edge. Later changes to sum_in/carry_in do not
//    affect an in-flight result.
//  - in_valid during RUN/DONE is ignored (not accepted), and the source must hold it.
//  - out_valid stays high and result holds for any length of out_ready=0 backpressure.
//  - CHUNK >= OPW: NCH=1, single-cycle RUN.
//  - Reset asserted mid-RUN or in DONE: in-flight operation is discarded, returns to IDLE
//    reset values; no output handshake occurs.
// CONFIGURATION
//  CSA_RES_BTB_EN defined:
//    In DONE, in_ready = out_ready. When out and in handshakes fire on the same edge, the new
//    operands are latched and the FSM goes straight to RUN (throughput 1 result per NCH+1 clk).
//  CSA_RES_BTB_EN undefined:
//    in_ready=1 only in IDLE; one idle clock between results (1 per NCH+2 clk).
// TESTING  (WIDTH=6, CHUNK=2 unless stated)
//  1. Reset mid-RUN: assert rst during cycle 2 -> out_valid=0, in_ready=1, result=0
//     immediately; next op is correct.
//  2. sum=6'h3F, carry=6'h3F -> result=8'hBD (189), out_valid exactly 4 clk after accept.
//  3. sum=6'h15, carry=6'h0A -> result=8'h29 (21+20=41). Hold out_ready=0 for 5 clk:
//     result/out_valid stable, in_ready=0.
//  4. sum=0, carry=0 -> result=0. Then sum=6'h01, carry=6'h20 -> result=8'h41. in_valid held
//     through RUN is accepted only once.
//  5. CHUNK=7 and CHUNK=1 with sum=6'h2A, carry=6'h33 -> result=8'h90 (144), latency 1 and 7.
//  6. BTB: 3 random pairs, in_valid and out_ready held 1 -> results match the model.
//     With CSA_RES_BTB_EN, accepts are 5 clk apart; without it, 6 clk apart.

Source files
------------

// File: rtl/csa_resolver.sv
// Resolves a carry-save (sum, carry) pair to binary by rippling CHUNK bits per clock.
// Optional back-to-back accept in DONE: define CSA_RES_BTB_EN.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// RUN   | one chunk of the ripple add per clock
// DONE  | result presented, waiting for out_ready
module csa_resolver #(
   parameter int WIDTH = 6,
   parameter int CHUNK = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   sum_in,
   input  logic [WIDTH-1:0]   carry_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH+1:0]   result
);
   localparam int OPW = WIDTH + 1;
   localparam int NCH = (OPW + CHUNK - 1) / CHUNK;
   localparam int PW  = NCH * CHUNK;
   localparam int RW  = WIDTH + 2;
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   a_q, b_q, acc_q, acc_d;
   logic [CW-1:0]   cnt_q;
   logic            c_q;
   logic [RW-1:0]   result_q;
   logic            load, step;
   logic [CHUNK:0]  tot;
   logic [PW:0]     full;
   int              idx;

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt_q == LAST) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
`ifdef CSA_RES_BTB_EN
            in_ready = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  load    = 1'b1;
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
`else
            if (out_ready) state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // Chunk adder: the only arithmetic in the block, CHUNK+1 bits wide.
   always_comb begin
      idx   = int'(cnt_q) * CHUNK;
      tot   = {1'b0, a_q[idx +: CHUNK]} + {1'b0, b_q[idx +: CHUNK]} + {{CHUNK{1'b0}}, c_q};
      acc_d = acc_q;
      acc_d[idx +: CHUNK] = tot[CHUNK-1:0];
      full  = {tot[CHUNK], acc_d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         c_q      <= 1'b0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            a_q   <= PW'({1'b0, sum_in});
            b_q   <= PW'({carry_in, 1'b0});
            cnt_q <= '0;
            c_q   <= 1'b0;
         end else if (step) begin
            acc_q <= acc_d;
            c_q   <= tot[CHUNK];
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) result_q <= full[RW-1:0];
         end
      end
   end

   assign result = result_q;
endmodule

// File: tb/tb_csa_resolver.sv
// Randomized and directed bench for csa_resolver with a queue scoreboard and a decoupled monitor.
module tb_csa_resolver;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0, out_ready = 1'b1;
   logic       in_ready, out_valid;
   logic [5:0] sum_in = '0, carry_in = '0;
   logic [7:0] result;

   logic       x_valid = 1'b0, x_oready = 1'b1;
   logic [5:0] x_sum = '0, x_carry = '0;
   logic       x_irdy7, x_ovld7, x_irdy1, x_ovld1;
   logic [7:0] x_res7, x_res1;

   int n_chk = 0, n_fail = 0;
   int cyc = 0, last_acc = 0, n_acc = 0;
   logic prev_ov = 1'b0;
   int sb[$];

`ifdef CSA_RES_BTB_EN
   localparam int GAP = 5;
`else
   localparam int GAP = 6;
`endif

   csa_resolver #(.WIDTH(6), .CHUNK(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .sum_in(sum_in), .carry_in(carry_in), .out_valid(out_valid),
      .out_ready(out_ready), .result(result));

   csa_resolver #(.WIDTH(6), .CHUNK(7)) u_c7 (
      .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(x_irdy7),
      .sum_in(x_sum), .carry_in(x_carry), .out_valid(x_ovld7),
      .out_ready(x_oready), .result(x_res7));

   csa_resolver #(.WIDTH(6), .CHUNK(1)) u_c1 (
      .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(x_irdy1),
      .sum_in(x_sum), .carry_in(x_carry), .out_valid(x_ovld1),
      .out_ready(x_oready), .result(x_res1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int model(input int s, input int c);
      return s + 2 * c;
   endfunction

   // Monitor: logs accepts into the scoreboard and pops on each output handshake.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         prev_ov = 1'b0;
      end else begin
         if (out_valid && !prev_ov) check("latency", cyc - last_acc, 4);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) check("unexpected_output", 1, 0);
            else check("result", int'(result), sb.pop_front());
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(int'(sum_in), int'(carry_in)));
            last_acc = cyc + 1;
            n_acc++;
         end
         prev_ov = out_valid;
      end
   end

   task automatic send(input logic [5:0] s, input logic [5:0] c);
      bit got = 0;
      @(posedge clk); #1;
      sum_in = s; carry_in = c; in_valid = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (in_ready) got = 1;
      end
      if (!got) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) ok = 1;
      end
      if (!ok) check("drain_timeout", 0, 1);
   endtask

   initial begin
      int acc0, e, lat7, lat1, r7, r1;
      bit seen;
      int edges[3];
      logic [5:0] rs[3], rc[3];

      repeat (2) @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_result", int'(result), 0);
      @(posedge clk); #1 rst = 1'b0;

      // Reset during the second RUN cycle discards the operation.
      send(6'h3F, 6'h3F);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      check("midrun_out_valid", int'(out_valid), 0);
      check("midrun_in_ready", int'(in_ready), 1);
      check("midrun_result", int'(result), 0);
      @(negedge clk); @(posedge clk); #1 rst = 1'b0;

      send(6'h3F, 6'h3F);
      drain();

      out_ready = 1'b0;
      send(6'h15, 6'h0A);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      if (!seen) check("bp_timeout", 0, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_result", int'(result), 8'h29);
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_in_ready", int'(in_ready), 0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      drain();

      send(6'h00, 6'h00);
      drain();
      acc0 = n_acc;
      send(6'h01, 6'h20);
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1 in_valid = 1'b0;
      drain();
      check("single_accept", n_acc - acc0, 1);

      // Back-to-back random pairs with in_valid and out_ready held high.
      for (int k = 0; k < 3; k++) begin
         rs[k] = 6'($urandom_range(0, 63));
         rc[k] = 6'($urandom_range(0, 63));
      end
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         seen = 0;
         sum_in = rs[k]; carry_in = rc[k]; in_valid = 1'b1;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (in_ready) seen = 1;
         end
         if (!seen) check("btb_timeout", 0, 1);
         edges[k] = cyc + 1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain();
      check("btb_gap1", edges[1] - edges[0], GAP);
      check("btb_gap2", edges[2] - edges[1], GAP);

      // Chunk widths 7 and 1 side by side.
      @(posedge clk); #1;
      x_sum = 6'h2A; x_carry = 6'h33; x_valid = 1'b1;
      @(negedge clk);
      check("x_ready7", int'(x_irdy7), 1);
      check("x_ready1", int'(x_irdy1), 1);
      e = cyc + 1;
      @(posedge clk); #1 x_valid = 1'b0;
      lat7 = -1; lat1 = -1; r7 = -1; r1 = -1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (x_ovld7 && lat7 < 0) begin lat7 = cyc - e; r7 = int'(x_res7); end
         if (x_ovld1 && lat1 < 0) begin lat1 = cyc - e; r1 = int'(x_res1); end
      end
      check("c7_latency", lat7, 1);
      check("c7_result", r7, model(8'h2A, 8'h33));
      check("c1_latency", lat1, 7);
      check("c1_result", r1, 8'h90);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
